// File: rtl/instr_fetch_seq_pkg.sv
// Shared state encodings and counter sizing for the byte-serial instruction fetch sequencer.
package instr_fetch_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Byte index counters only ever need to address NBYTES lanes.
  function automatic int cnt_width(input int nbytes);
    return (nbytes < 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/instr_fetch_seq_dff8bit.sv
// dff8bit: one instruction byte lane, loads d_i when en_i is high, clears on synchronous rst.
module dff8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [7:0] d_i,
  output logic [7:0] q_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_o <= 8'h00;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: reads NBYTES bytes from base_addr into instr; done NBYTES+2 cycles after start, start ignored while busy.
// INSTR_FETCH_BIG_ENDIAN_EN puts the first byte in the MSB lane; otherwise little-endian.
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   instr
);

  localparam int CNT_W = cnt_width(NBYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]    issue_idx_q, issue_idx_d;
  logic [CNT_W-1:0]    cap_idx_q, cap_idx_d;
  logic                mem_rd_q, mem_rd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cap_vld_q, cap_vld_d;
  logic [CNT_W-1:0]    lane_sel;
  logic [NBYTES-1:0]   lane_en;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    mem_addr_d  = mem_addr_q;
    issue_idx_d = issue_idx_q;
    mem_rd_d    = mem_rd_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    // Read data returns one cycle after its strobe, so capture trails issue by one.
    cap_vld_d   = mem_rd_q;
    cap_idx_d   = cap_vld_q ? cap_idx_q + CNT_W'(1) : cap_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d      = base_addr;
          issue_idx_d = '0;
          cap_idx_d   = '0;
          mem_rd_d    = 1'b1;
          mem_addr_d  = base_addr;
          busy_d      = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_idx_q == LAST_IDX) begin
          mem_rd_d = 1'b0;
          state_d  = S_DRAIN;
        end else begin
          issue_idx_d = issue_idx_q + CNT_W'(1);
          mem_addr_d  = base_q + ADDR_W'(issue_idx_q) + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        mem_rd_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      mem_addr_q  <= '0;
      issue_idx_q <= '0;
      cap_idx_q   <= '0;
      mem_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cap_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      mem_addr_q  <= mem_addr_d;
      issue_idx_q <= issue_idx_d;
      cap_idx_q   <= cap_idx_d;
      mem_rd_q    <= mem_rd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cap_vld_q   <= cap_vld_d;
    end
  end

`ifdef INSTR_FETCH_BIG_ENDIAN_EN
  assign lane_sel = LAST_IDX - cap_idx_q;
`else
  assign lane_sel = cap_idx_q;
`endif

  for (genvar g = 0; g < NBYTES; g++) begin : g_lane
    assign lane_en[g] = cap_vld_q && (lane_sel == CNT_W'(g));

    dff8bit u_lane (
      .clk  (clk),
      .rst  (rst),
      .en_i (lane_en[g]),
      .d_i  (mem_rdata),
      .q_o  (instr[8*g +: 8])
    );
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: main 4-byte/8-bit-address instance plus a 2-byte/6-bit-address instance.
module tb_instr_fetch_seq;

  localparam int AW  = 8;
  localparam int NB  = 4;
  localparam int AW2 = 6;
  localparam int NB2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, start2;
  logic [AW-1:0]     base_addr, mem_addr;
  logic [AW2-1:0]    base_addr2, mem_addr2;
  logic              mem_rd, mem_rd2, busy, busy2, done, done2;
  logic [7:0]        mem_rdata, mem_rdata2;
  logic [8*NB-1:0]   instr;
  logic [8*NB2-1:0]  instr2;

  logic [7:0] mem  [256];
  logic [7:0] mem2 [64];

  int checks = 0;
  int errors = 0;

  instr_fetch_seq #(.ADDR_W(AW), .NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .instr(instr)
  );

  instr_fetch_seq #(.ADDR_W(AW2), .NBYTES(NB2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .base_addr(base_addr2),
    .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
    .busy(busy2), .done(done2), .instr(instr2)
  );

  // Synchronous memories: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd)  mem_rdata  <= mem[mem_addr];
    if (mem_rd2) mem_rdata2 <= mem2[mem_addr2];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected word: byte at base+k (mod 2^aw) placed in lane k, or lane nb-1-k when big-endian.
  function automatic logic [63:0] model_word(input int base, input int nb, input int aw, input bit second);
    logic [63:0] w;
    int idx, lane;
    w = '0;
    for (int k = 0; k < nb; k++) begin
      idx = (base + k) % (1 << aw);
`ifdef INSTR_FETCH_BIG_ENDIAN_EN
      lane = nb - 1 - k;
`else
      lane = k;
`endif
      w[8*lane +: 8] = second ? mem2[idx] : mem[idx];
    end
    return w;
  endfunction

  // Called at a negedge; glitch>0 re-asserts start (base 0x40) during that busy cycle.
  task automatic run_fetch(input logic [AW-1:0] base, input int glitch);
    logic [63:0]   exp;
    logic [AW-1:0] ea;
    exp       = model_word(int'(base), NB, AW, 1'b0);
    start     = 1'b1;
    base_addr = base;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= NB + 3; c++) begin
      if (c == glitch) begin
        start     = 1'b1;
        base_addr = 8'h40;
      end else begin
        start = 1'b0;
      end
      ea = base + AW'(c - 1);
      check("mem_rd", mem_rd, c <= NB);
      if (c <= NB) check("mem_addr", mem_addr, ea);
      check("busy", busy, c <= NB + 1);
      check("done", done, c == NB + 2);
      if (c >= NB + 2) check("instr", instr, exp);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] rb;
    int gl;
    logic [63:0] exp;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 64; i++)  mem2[i] = 8'($urandom);
    rst = 1'b1; start = 1'b0; start2 = 1'b0; base_addr = '0; base_addr2 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_instr2", instr2, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic fetch and address wrap-around.
    mem[8'h10] = 8'h8C; mem[8'h11] = 8'h04; mem[8'h12] = 8'h00; mem[8'h13] = 8'h20;
    run_fetch(8'h10, 0);
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
    run_fetch(8'hFE, 0);
    // Start while busy must be ignored.
    run_fetch(8'h10, 2);

    // Randomized fetches with random idle gaps and stray starts while busy.
    repeat (12) begin
      rb = AW'($urandom);
      for (int k = 0; k < NB; k++) mem[8'(rb + AW'(k))] = 8'($urandom);
      gl = $urandom_range(0, NB + 1);
      run_fetch(rb, gl);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Back-to-back: start held high, done every NB+2 cycles, next issue right after done.
    exp       = model_word(8'h20, NB, AW, 1'b0);
    start     = 1'b1;
    base_addr = 8'h20;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= 20; c++) begin
      check("b2b_done", done, (c % (NB + 2)) == 0);
      check("b2b_mem_rd", mem_rd, (c % (NB + 2)) >= 1 && (c % (NB + 2)) <= NB);
      if (done) check("b2b_instr", instr, exp);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (NB + 4) @(negedge clk);

    // Reset mid-fetch: outputs clear, no done, then a clean fetch.
    start     = 1'b1;
    base_addr = 8'h30;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mem_rd", mem_rd, 0);
    check("mid_rst_instr", instr, 0);
    check("mid_rst_done", done, 0);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("post_rst_done", done, 0);
      check("post_rst_mem_rd", mem_rd, 0);
      @(negedge clk);
    end
    run_fetch(8'h50, 0);

    // Narrow instance: 2 bytes, 6-bit address wrapping 3F -> 00.
    exp        = model_word(6'h3F, NB2, AW2, 1'b1);
    start2     = 1'b1;
    base_addr2 = 6'h3F;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 1; c <= NB2 + 3; c++) begin
      check("n2_mem_rd", mem_rd2, c <= NB2);
      if (c == 1) check("n2_addr0", mem_addr2, 6'h3F);
      if (c == 2) check("n2_addr1", mem_addr2, 6'h00);
      check("n2_busy", busy2, c <= NB2 + 1);
      check("n2_done", done2, c == NB2 + 2);
      if (c >= NB2 + 2) check("n2_instr", instr2, exp);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
